tile_feeder: RTL
================

TILE_FEEDER -- requirements
Module: tile_feeder

Interface
REQ-001 SHALL have parameter SIZE, default 2, giving the tile edge length (tile is SIZE x SIZE bytes).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port run, input, 1 bit: level enable; while high, the block fetches and feeds tiles continuously.
REQ-005 SHALL have port pop, output, 1 bit: pop request to the upstream tile FIFO.
REQ-006 SHALL have port pop_rdy, input, 1 bit: upstream FIFO non-empty.
REQ-007 SHALL have port tile_in, input, 8 bits x [SIZE][SIZE]: FIFO registered output, valid the cycle after pop.
REQ-008 SHALL have port feed_valid, output, 1 bit: row_data/row_valid carry a skew step.
REQ-009 SHALL have port feed_rdy, input, 1 bit: array accepts the step; a transfer occurs when feed_valid && feed_rdy.
REQ-010 SHALL have port row_data, output, 8 bits x [SIZE]: one byte per systolic row.
REQ-011 SHALL have port row_valid, output, SIZE bits: per-row element-present flag.
REQ-012 SHALL have port done, output, 1 bit: one-cycle pulse on the final transfer of a tile.
REQ-013 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-014 SHALL have port tile_count, output, 16 bits: number of tiles fully fed, wraps modulo 2^16.

Function
REQ-015 SHALL implement states IDLE, POP, CAPTURE, FEED.
REQ-016 IDLE SHALL go to POP when run && pop_rdy; otherwise it SHALL stay in IDLE.
REQ-017 pop SHALL be high exactly in the POP cycle, a single cycle per tile; POP SHALL go unconditionally to CAPTURE.
REQ-018 CAPTURE SHALL latch tile_in into an internal tile register, clear step counter k, and go to FEED.
REQ-019 In FEED with step k (0..2*SIZE-2): feed_valid=1; row_data[r] = tile[r][k-r] and row_valid[r]=1 if 0<=k-r<SIZE, else row_data[r]=0 and row_valid[r]=0.
REQ-020 k SHALL advance only on a transfer; while feed_rdy=0, k and all FEED outputs SHALL hold.
REQ-021 On the transfer with k=2*SIZE-2, done SHALL pulse that same cycle, tile_count SHALL increment, and the next state SHALL be IDLE.
REQ-022 Outside FEED, feed_valid, row_valid, and row_data SHALL be 0.
REQ-023 Latency SHALL be: run&&pop_rdy sampled in IDLE at cycle 0 -> pop at cycle 1 -> first feed_valid at cycle 3; best-case period SHALL be 2*SIZE+2 cycles per tile.
REQ-024 Deasserting run after IDLE SHALL NOT abort the tile in flight; it SHALL only prevent the next fetch.
REQ-025 pop_rdy SHALL be ignored outside IDLE, since this block is the sole consumer.
REQ-026 k SHALL be max(1, $clog2(2*SIZE-1)) bits wide and SHALL never exceed 2*SIZE-2.

Reset
REQ-027 On rst_n low, the block SHALL enter IDLE immediately, independent of clk.
REQ-028 On rst_n low, pop, feed_valid, row_valid, row_data, done, busy, tile_count, k, and the tile register SHALL all be 0.
REQ-029 Reset mid-FEED SHALL discard the tile in flight; the FIFO is not rewound, and tile_count SHALL not count that tile.

Structure
REQ-030 The state enum and the feed-length constant (2*SIZE-1) SHALL live in shared package tpu_pkg.
REQ-031 SHALL be a single module with no sub-modules; the skew mux is combinational from k and the tile register.

Verification (SIZE=2)
REQ-032 Load tile [[1,2],[3,4]], run=1, feed_rdy=1 -> pop at cycle 1, then three steps: row_data (row0,row1) = (1,0),(2,3),(0,4); row_valid (row0,row1) = 10,11,01; done on the third step; tile_count=1.
REQ-033 Same tile, feed_rdy=0 for 2 cycles at k=1 -> (2,3) held for 3 cycles, no k advance, done delayed 2 cycles.
REQ-034 Three tiles queued, run held high -> pop pulses spaced 6 cycles apart, tile_count=3, no pop while busy.
REQ-035 run=1 with pop_rdy=0 -> stays in IDLE, pop=0, busy=0; raising pop_rdy -> pop on the next cycle.
REQ-036 Drop run at k=0 -> current tile completes with done, then the block returns to IDLE with no further pop.
REQ-037 Assert rst_n low asynchronously at k=1 -> all outputs 0 immediately, IDLE, tile_count unchanged from its pre-tile value (then 0 by reset).

Source files
------------

// File: rtl/tpu_pkg.sv
// Shared types and constants for the tile feeder.
// State encoding and feed-length helpers.
package tpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_POP,
    ST_CAPTURE,
    ST_FEED
  } tf_state_e;

  localparam int DEF_SIZE = 2;
  localparam int FEED_LEN = 2 * DEF_SIZE - 1;

  // Skew steps needed to push one SIZE x SIZE tile.
  function automatic int feed_len(input int size);
    return 2 * size - 1;
  endfunction

endpackage

// File: rtl/tile_feeder.sv
// Pops one tile from the upstream FIFO and feeds it
// diagonally skewed into a SIZE-row systolic array.
module tile_feeder
  import tpu_pkg::*;
#(
  parameter int SIZE = DEF_SIZE
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           run,
  output logic                           pop,
  input  logic                           pop_rdy,
  input  logic [SIZE-1:0][SIZE-1:0][7:0] tile_in,
  output logic                           feed_valid,
  input  logic                           feed_rdy,
  output logic [SIZE-1:0][7:0]           row_data,
  output logic [SIZE-1:0]                row_valid,
  output logic                           done,
  output logic                           busy,
  output logic [15:0]                    tile_count
);

  localparam int LAST = feed_len(SIZE) - 1;
  localparam int KW =
    (SIZE > 1) ? $clog2(2 * SIZE - 1) : 1;

  tf_state_e r_state;
  tf_state_e w_next;

  logic [SIZE-1:0][SIZE-1:0][7:0] r_tile;
  logic [KW-1:0]                  r_k;
  logic [15:0]                    r_count;

  logic w_last;
  logic w_xfer;

  assign w_last = (r_k == KW'(LAST));
  assign w_xfer = (r_state == ST_FEED) && feed_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (run && pop_rdy) begin
          w_next = ST_POP;
        end
      end
      ST_POP: begin
        w_next = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        w_next = ST_FEED;
      end
      ST_FEED: begin
        if (w_xfer && w_last) begin
          w_next = ST_IDLE;
        end
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tile <= '0;
      r_k    <= '0;
    end else if (r_state == ST_CAPTURE) begin
      r_tile <= tile_in;
      r_k    <= '0;
    end else if (w_xfer && !w_last) begin
      r_k <= r_k + KW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (w_xfer && w_last) begin
      r_count <= r_count + 16'd1;
    end
  end

  // Row r sees column k-r of its tile row while in range.
  always_comb begin
    pop        = (r_state == ST_POP);
    busy       = (r_state != ST_IDLE);
    feed_valid = (r_state == ST_FEED);
    done       = w_xfer && w_last;
    row_data   = '0;
    row_valid  = '0;
    if (r_state == ST_FEED) begin
      for (int r = 0; r < SIZE; r++) begin
        for (int c = 0; c < SIZE; c++) begin
          if (int'(r_k) == r + c) begin
            row_data[r]  = r_tile[r][c];
            row_valid[r] = 1'b1;
          end
        end
      end
    end
  end

  assign tile_count = r_count;

endmodule
